pipelined_addsub: RTL and testbench

- Parametrised, pipelined WIDTH-bit adder/subtractor built from per-bit full-adder cells.
- The carry chain is split into STAGES registered segments, so one operation is accepted per cycle with a fixed latency of STAGES cycles.
- Valid/ready handshakes on input and output, with whole-pipeline stall on backpressure.
- Provides carry-out and signed overflow. Used as the datapath adder for accumulators and ALU paths where a single ripple chain misses timing.

---
 rtl/pipelined_addsub.sv | 106 ++++++++++
 tb/tb_pipelined_addsub.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the ripple carry chain is cut into STAGES
// registered segments with valid/ready flow control and whole-pipeline stall.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  logic adv;

  // The whole pipe moves together unless a valid result is being held back.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO   = SEG * k;
    localparam int unsigned REM  = WIDTH - LO;
    localparam int unsigned DONE = LO + SEG;

    logic [REM-1:0]  a_in;
    logic [REM-1:0]  b_in;
    logic            v_in;
    logic [SEG:0]    c;
    logic [SEG-1:0]  s_seg;
    logic [DONE-1:0] s_next;
    logic            v_q;
    logic            c_q;
    logic [DONE-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = b ^ {WIDTH{sub}};
      assign c[0]   = cin ^ sub;
      assign v_in   = in_valid;
      assign s_next = s_seg;
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c[0]   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {s_seg, g_stage[k-1].s_q};
    end

    // Full-adder cells for this segment.
    for (genvar j = 0; j < SEG; j++) begin : g_bit
      assign s_seg[j] = a_in[j] ^ b_in[j] ^ c[j];
      assign c[j+1]   = (a_in[j] & b_in[j]) | (a_in[j] & c[j]) | (b_in[j] & c[j]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c[SEG];
        s_q <= s_next;
      end
    end

    if (k + 1 < STAGES) begin : g_fwd
      // Operand bits still to be consumed by later segments.
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= a_in[REM-1:SEG];
          b_q <= b_in[REM-1:SEG];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c[SEG] ^ c[SEG-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed vectors, throughput, backpressure
// and mid-stream reset on 16/4, plus randomised streams on several WIDTH/STAGES pairs.
module tb_pipelined_addsub;

  localparam int NCFG = 4;
  localparam int unsigned CFG_W [NCFG] = '{16, 8, 8, 32};
  localparam int unsigned CFG_S [NCFG] = '{4, 1, 8, 4};

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int unsigned cyc;
    int unsigned st;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add, overflow from operand/result sign bits.
  function automatic exp_t model(input int unsigned w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic su);
    exp_t r;
    logic [63:0] mask, ae, be, tot;
    mask  = (64'd1 << w) - 64'd1;
    ae    = {32'd0, av} & mask;
    be    = (su ? ~{32'd0, bv} : {32'd0, bv}) & mask;
    tot   = ae + be + 64'(ci ^ su);
    r.s   = 32'(tot & mask);
    r.co  = tot[w];
    r.ov  = (ae[w-1] == be[w-1]) && (tot[w-1] != ae[w-1]);
    r.cyc = 0;
    r.st  = 0;
    return r;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned W = CFG_W[g];
    localparam int unsigned S = CFG_S[g];

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_ready = 1'b1;
    logic         fin = 1'b0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] sum;
    exp_t         q[$];
    int unsigned  stalls = 0;
    logic         hold = 1'b0;
    logic [W+2:0] last = '0;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Monitor: pop/compare on output handshake, push on input handshake.
    initial forever begin : mon
      exp_t e;
      @(negedge clk);
      if (rst) begin
        q.delete();
        hold = 1'b0;
      end else begin
        if (hold)
          chk($sformatf("c%0d.hold", g), 64'({out_valid, cout, ovf, sum}), 64'(last));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("c%0d.spurious_out", g), 64'(q.size()), 64'd1);
          end else begin
            e = q.pop_front();
            chk($sformatf("c%0d.sum", g), 64'(sum), 64'(e.s));
            chk($sformatf("c%0d.cout", g), 64'(cout), 64'(e.co));
            chk($sformatf("c%0d.ovf", g), 64'(ovf), 64'(e.ov));
            chk($sformatf("c%0d.latency", g), 64'(cyc - e.cyc), 64'(S + stalls - e.st));
          end
        end
        if (in_valid && in_ready) begin
          e     = model(W, 32'(a), 32'(b), cin, sub);
          e.cyc = cyc;
          e.st  = stalls;
          q.push_back(e);
        end
        if (out_valid && !out_ready) stalls++;
        hold = out_valid && !out_ready;
        last = {1'b1, cout, ovf, sum};
      end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic su, output int unsigned waits);
      a = av; b = bv; cin = ci; sub = su; in_valid = 1'b1;
      waits = 0;
      #1;
      while (!in_ready && waits < 100) begin
        @(posedge clk); #1;
        waits++;
      end
      if (waits >= 100) chk($sformatf("c%0d.send_timeout", g), 64'(waits), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int unsigned t = 0;
      while (q.size() != 0 && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      chk($sformatf("c%0d.drain", g), 64'(q.size()), 64'd0);
    endtask

    task automatic rand_run(input int unsigned n);
      int unsigned sent = 0;
      int unsigned t = 0;
      logic pend = 1'b0;
      while (sent < n && t < 20 * n) begin
        if (!pend && $urandom_range(0, 3) != 0) begin
          a = W'($urandom); b = W'($urandom);
          cin = 1'($urandom); sub = 1'($urandom);
          pend = 1'b1;
        end
        in_valid  = pend;
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (pend && in_ready) begin
          pend = 1'b0;
          sent++;
        end
        @(posedge clk); #1;
        t++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk($sformatf("c%0d.rand_sent", g), 64'(sent), 64'(n));
    endtask

    if (g == 0) begin : g_dir
      initial begin
        logic [15:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0005};
        logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0003};
        logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int unsigned w, idx, st, t;
        logic        stall_done, acc;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.sum", 64'(sum), 64'd0);
        chk("rst.cout", 64'(cout), 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        // Carry across every segment, signed overflow, subtract/borrow cases.
        for (int i = 0; i < 5; i++) send(W'(ta[i]), W'(tb[i]), tc[i], ts[i], w);
        drain();

        // Back-to-back beats: no wait states expected.
        for (int i = 0; i < 8; i++) begin
          send(W'(i), W'(3 * i), 1'b0, 1'b0, w);
          chk("tput.waits", 64'(w), 64'd0);
        end
        drain();

        // Hold out_ready low for 3 cycles once the first result shows up.
        idx = 0; st = 0; stall_done = 1'b0;
        for (t = 0; t < 60 && idx < 8; t++) begin
          a = W'(16'h0100 + idx); b = W'(idx); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
          if (out_valid && !stall_done) begin
            st = 3;
            stall_done = 1'b1;
          end
          out_ready = (st == 0);
          if (st > 0) st--;
          #1;
          if (!out_ready) chk("bp.in_ready", 64'(in_ready), 64'd0);
          acc = in_ready;
          @(posedge clk); #1;
          if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp.accepted", 64'(idx), 64'd8);
        drain();

        // Reset with three beats in flight plus one offered during reset.
        for (int i = 0; i < 3; i++) send(W'(16'h1000 + i), W'(i), 1'b0, 1'b0, w);
        rst = 1'b1; a = W'(16'h2222); b = W'(16'h1111); in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst.sum", 64'(sum), 64'd0);
        send(W'(16'h1234), W'(16'h0101), 1'b1, 1'b0, w);
        drain();

        rand_run(300);
        drain();
        fin = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rand_run(1000);
        drain();
        fin = 1'b1;
      end
    end
  end

  initial begin
    for (int t = 0; t < 30000; t++) begin
      if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) break;
      @(posedge clk);
    end
    chk("all_finished", 64'({g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin, g_cfg[3].fin}), 64'hF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
